// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Used by m_fetch_buf and m_fetch_fifo.
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(
    input logic [XLEN-1:0] pc
  );
    return pc + PC_INC;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(
    input logic [XLEN-1:0] pc
  );
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small synchronous-reset FIFO of fetch entries.
// Flush has priority over push and pop; head is a zero-latency view.
module m_fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  logic            w_do_push;
  logic            w_do_pop;

  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign dout  = r_mem[r_rp];

  assign w_do_push = push & !full & !flush;
  assign w_do_pop  = pop & !empty & !flush;

  // Pointer and occupancy bookkeeping; flush empties the queue.
  always_ff @(posedge w_clk) begin
    if (w_rst || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + AW'(1);
      if (w_do_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; contents past the head are don't-care.
  always_ff @(posedge w_clk) begin
    if (!w_rst && w_do_push) begin
      r_mem[r_wp] <= din;
    end
  end

endmodule

// File: rtl/m_fetch_buf.sv
// Fetch front end: in-order imem requests, response FIFO, redirect flush.
// Optional macro FETCH_PERF_EN adds bubble and discard counters.
module m_fetch_buf
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_redirect,
  input  logic [31:0] w_tpc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_v,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc,
  input  logic        i_rdy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_bubble_cnt,
  output logic [31:0] o_discard_cnt
`endif
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fpc;
  logic [31:0]   r_rpc;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_disc;

  logic [OW-1:0] w_out_nxt;
  logic [31:0]   w_tgt;
  logic          w_room;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;

  logic [CW-1:0] w_cnt;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_head;
  fetch_entry_t  w_din;

  assign w_tgt = pc_align(w_tpc);

  // Space is reserved for every in-flight request.
  assign w_room = !w_full
                & ((32'(w_cnt) + 32'(r_out)) < 32'(DEPTH));

  assign o_imem_req = !w_rst
                    & !w_redirect
                    & (r_out < OW'(MAX_OUT))
                    & w_room;

  assign o_imem_addr = r_fpc;

  assign w_out_nxt = r_out
                   + OW'(o_imem_req)
                   - OW'(i_imem_valid);

  assign w_drop = i_imem_valid & (r_disc != '0);
  assign w_push = i_imem_valid & !w_drop & !w_redirect;
  assign w_pop  = o_v & i_rdy & !w_redirect;

  assign w_din.ir = i_imem_rdata;
  assign w_din.pc = r_rpc;

  m_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_redirect),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_cnt)
  );

  assign o_v  = !w_empty;
  assign o_ir = w_empty ? NOP : w_head.ir;
  assign o_pc = w_empty ? 32'h0 : w_head.pc;

  // Fetch/response PCs plus outstanding and discard tracking.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_fpc  <= RESET_PC;
      r_rpc  <= RESET_PC;
      r_out  <= '0;
      r_disc <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (w_redirect) begin
        r_fpc  <= w_tgt;
        r_rpc  <= w_tgt;
        r_disc <= w_out_nxt;
      end else begin
        if (o_imem_req) r_fpc <= pc_next(r_fpc);
        if (w_push)     r_rpc <= pc_next(r_rpc);
        if (w_drop)     r_disc <= r_disc - OW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_bubble;
  logic [31:0] r_dcnt;

  assign o_bubble_cnt  = r_bubble;
  assign o_discard_cnt = r_dcnt;

  // Saturating bubble and dropped-response counters.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_bubble <= '0;
      r_dcnt   <= '0;
    end else begin
      if (!o_v && !w_redirect && r_bubble != '1)
        r_bubble <= r_bubble + 32'd1;
      if (w_drop && r_dcnt != '1)
        r_dcnt <= r_dcnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m_fetch_buf.sv
// Directed bench for m_fetch_buf with an in-order variable-latency imem.
// A second instance checks RESET_PC wrap-around.
module tb_m_fetch_buf;

  logic        w_clk = 1'b0;
  logic        w_rst;
  logic        w_redirect;
  logic [31:0] w_tpc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_valid;
  logic [31:0] i_imem_rdata;
  logic        o_v;
  logic [31:0] o_ir;
  logic [31:0] o_pc;
  logic        i_rdy;

  logic        req2;
  logic [31:0] addr2;
  logic        v2_in;
  logic [31:0] rdata2;
  logic        o_v2;
  logic [31:0] o_ir2;
  logic [31:0] o_pc2;

`ifdef FETCH_PERF_EN
  logic [31:0] bub_cnt;
  logic [31:0] dis_cnt;
  logic [31:0] bub_cnt2;
  logic [31:0] dis_cnt2;
`endif

  int n_vec = 0;
  int n_err = 0;
  int lat = 1;
  int tb_out = 0;
  bit inv_en = 1'b0;

  logic [3:0]  d_v;
  logic [31:0] d_a [4];
  logic        m2_v;
  logic [31:0] m2_a;

  always #5 w_clk = ~w_clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  m_fetch_buf #(
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'h0)
  ) u_dut (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_redirect   (w_redirect),
    .w_tpc        (w_tpc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_valid (i_imem_valid),
    .i_imem_rdata (i_imem_rdata),
    .o_v          (o_v),
    .o_ir         (o_ir),
    .o_pc         (o_pc),
    .i_rdy        (i_rdy)
`ifdef FETCH_PERF_EN
    ,
    .o_bubble_cnt  (bub_cnt),
    .o_discard_cnt (dis_cnt)
`endif
  );

  m_fetch_buf #(
    .DEPTH    (4),
    .MAX_OUT  (2),
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut2 (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_redirect   (1'b0),
    .w_tpc        (32'h0),
    .o_imem_req   (req2),
    .o_imem_addr  (addr2),
    .i_imem_valid (v2_in),
    .i_imem_rdata (rdata2),
    .o_v          (o_v2),
    .o_ir         (o_ir2),
    .o_pc         (o_pc2),
    .i_rdy        (1'b1)
`ifdef FETCH_PERF_EN
    ,
    .o_bubble_cnt  (bub_cnt2),
    .o_discard_cnt (dis_cnt2)
`endif
  );

  // In-order memory: delay line, latency selected by lat (1..4).
  always @(posedge w_clk) begin
    if (w_rst) begin
      d_v <= '0;
    end else begin
      d_v <= {d_v[2:0], o_imem_req};
    end
    d_a[0] <= o_imem_addr;
    d_a[1] <= d_a[0];
    d_a[2] <= d_a[1];
    d_a[3] <= d_a[2];
  end

  assign i_imem_valid = d_v[lat-1];
  assign i_imem_rdata = img(d_a[lat-1]);

  // Single-cycle memory for the second instance.
  always @(posedge w_clk) begin
    m2_v <= w_rst ? 1'b0 : req2;
    m2_a <= addr2;
  end

  assign v2_in  = m2_v;
  assign rdata2 = img(m2_a);

  // Outstanding requests seen at the memory port.
  always @(posedge w_clk) begin
    if (w_rst) tb_out <= 0;
    else tb_out <= tb_out + int'(o_imem_req) - int'(i_imem_valid);
  end

  always @(negedge w_clk) begin
    if (inv_en && !w_rst) begin
      n_vec++;
      assert (tb_out <= 2) else begin
        n_err++;
        $error("FAIL outstanding obs=%0d max=2", tb_out);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge w_clk);
    @(negedge w_clk);
  endtask

  task automatic next_entry(input string tag,
                            input logic [31:0] pc);
    int k = 0;
    while (!o_v && k < 20) begin
      step();
      k++;
    end
    chk({tag, " v"}, 32'(o_v), 32'h1);
    chk({tag, " pc"}, o_pc, pc);
    chk({tag, " ir"}, o_ir, img(pc));
    step();
  endtask

  task automatic do_reset(input int l);
    w_rst = 1'b1;
    w_redirect = 1'b0;
    i_rdy = 1'b1;
    step();
    lat = l;
    step();
    w_rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] e;
    int k;
    w_rst = 1'b1;
    w_redirect = 1'b0;
    w_tpc = 32'h0;
    i_rdy = 1'b1;
    step();
    step();
    inv_en = 1'b1;
    chk("rst v", 32'(o_v), 32'h0);
    chk("rst ir", o_ir, 32'h13);
    chk("rst pc", o_pc, 32'h0);
    chk("rst req", 32'(o_imem_req), 32'h0);

    do_reset(1);
    chk("c0 req", 32'(o_imem_req), 32'h1);
    chk("c0 addr", o_imem_addr, 32'h0);
    step();
    chk("c1 v", 32'(o_v), 32'h0);
    chk("c1 addr", o_imem_addr, 32'h4);
    step();
    chk("c2 v", 32'(o_v), 32'h1);
    next_entry("seq0", 32'h0);
    next_entry("seq4", 32'h4);
    next_entry("seq8", 32'h8);
    next_entry("seq12", 32'hC);

    i_rdy = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("full req", 32'(o_imem_req), 32'h0);
    chk("full v", 32'(o_v), 32'h1);
    chk("full pc", o_pc, 32'h10);
    i_rdy = 1'b1;
    #1;
    next_entry("drain16", 32'h10);
    next_entry("drain20", 32'h14);
    next_entry("drain24", 32'h18);
    next_entry("drain28", 32'h1C);
    next_entry("drain32", 32'h20);

    do_reset(3);
    chk("l3 c0 req", 32'(o_imem_req), 32'h1);
    step();
    chk("l3 c1 addr", o_imem_addr, 32'h4);
    step();
    chk("l3 maxout", 32'(o_imem_req), 32'h0);
    chk("l3 c2 v", 32'(o_v), 32'h0);
    w_redirect = 1'b1;
    w_tpc = 32'h100;
    #1;
    chk("l3 redir req", 32'(o_imem_req), 32'h0);
    step();
    w_redirect = 1'b0;
    #1;
    chk("l3 c3 v", 32'(o_v), 32'h0);
    next_entry("l3 t100", 32'h100);
    next_entry("l3 t104", 32'h104);
`ifdef FETCH_PERF_EN
    chk("perf discard", dis_cnt, 32'd2);
`endif

    do_reset(1);
    next_entry("rp0", 32'h0);
    next_entry("rp4", 32'h4);
    chk("rp pre v", 32'(o_v), 32'h1);
    chk("rp pre pc", o_pc, 32'h8);
    w_redirect = 1'b1;
    w_tpc = 32'h200;
    #1;
    step();
    w_redirect = 1'b0;
    #1;
    chk("rp flush v", 32'(o_v), 32'h0);
    chk("rp req", 32'(o_imem_req), 32'h1);
    chk("rp addr", o_imem_addr, 32'h200);
    next_entry("rp t200", 32'h200);
    next_entry("rp t204", 32'h204);

    w_redirect = 1'b1;
    w_tpc = 32'h40;
    #1;
    chk("bb1 req", 32'(o_imem_req), 32'h0);
    step();
    w_tpc = 32'h83;
    #1;
    chk("bb2 req", 32'(o_imem_req), 32'h0);
    step();
    w_redirect = 1'b0;
    #1;
    chk("bb addr", o_imem_addr, 32'h80);
    next_entry("bb t80", 32'h80);
    next_entry("bb t84", 32'h84);
`ifdef FETCH_PERF_EN
    chk("perf nodisc", dis_cnt, 32'd0);
`endif

    i_rdy = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("prerst v", 32'(o_v), 32'h1);
    chk("prerst req", 32'(o_imem_req), 32'h0);
    w_rst = 1'b1;
    #1;
    chk("midrst req", 32'(o_imem_req), 32'h0);
    step();
    chk("midrst v", 32'(o_v), 32'h0);
    chk("midrst ir", o_ir, 32'h13);
    chk("midrst pc", o_pc, 32'h0);

    do_reset(1);
    e = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      while (!o_v2 && k < 20) begin
        step();
        k++;
      end
      chk("wrap v", 32'(o_v2), 32'h1);
      chk("wrap pc", o_pc2, e);
      chk("wrap ir", o_ir2, img(e));
      e = e + 32'd4;
      step();
    end

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
